// File: rtl/obs_ctrl.sv
// Obstacle motion controller: moves one obstacle down the screen once per frame,
// respawning it at a pseudo-random column after a fixed number of frames.
module obs_ctrl #(
   parameter int unsigned OBS_W          = 32,
   parameter int unsigned OBS_H          = 32,
   parameter int unsigned MAX_X          = 640,
   parameter int unsigned MAX_Y          = 480,
   parameter int unsigned SPEED_INIT     = 1,
   parameter int unsigned SPEED_MAX      = 8,
   parameter int unsigned LEVEL_PASSES   = 4,
   parameter int unsigned RESPAWN_FRAMES = 30
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [10:0] pix_x_i,
   input  logic [10:0] pix_y_i,
   input  logic        start_i,
   input  logic        hit_i,
   output logic [10:0] x1_o,
   output logic [10:0] x2_o,
   output logic [10:0] y1_o,
   output logic [10:0] y2_o,
   output logic        obs_active_o,
   output logic        passed_o,
   output logic [3:0]  speed_o
);

   localparam int unsigned FCW = $clog2(RESPAWN_FRAMES + 1);
   localparam int unsigned PCW = $clog2(LEVEL_PASSES + 1);

   localparam logic [10:0] Park      = 11'h7FF;
   localparam logic [10:0] MaxY      = 11'(MAX_Y);
   localparam logic [10:0] DecRow    = 11'(MAX_Y + 1);
   localparam logic [10:0] LastCol   = 11'(MAX_X - OBS_W);
   localparam logic [10:0] ObsWm1    = 11'(OBS_W - 1);
   localparam logic [10:0] ObsHm1    = 11'(OBS_H - 1);
   localparam logic [3:0]  SpeedInit = 4'(SPEED_INIT);
   localparam logic [3:0]  SpeedMax  = 4'(SPEED_MAX);
   localparam logic [9:0]  LfsrSeed  = 10'h2A5;

   typedef enum logic [1:0] {StIdle, StWait, StFall} state_e;

   state_e           state_q, state_d;
   logic             dec_q;
   logic [9:0]       lfsr_q, lfsr_d;
   logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
   logic [PCW-1:0]   pass_cnt_q, pass_cnt_d;
   logic [PCW-1:0]   pass_inc;
   logic [3:0]       speed_q, speed_d;
   logic [10:0]      x_left_q, x_left_d;
   logic [10:0]      y_top_q, y_top_d;
   logic [10:0]      x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
   logic             active_q, active_d;
   logic             passed_q, passed_d;

   logic             dec, tick;
   logic [10:0]      col, spawn_x, y_next;

   // One tick per frame: rising edge of the "just past the last visible line" marker.
   assign dec  = (pix_y_i == DecRow) && (pix_x_i == 11'd0);
   assign tick = dec & ~dec_q;

   // x^10 + x^7 + 1 Fibonacci LFSR, free-running.
   assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

   // Fold the 10-bit random value into the legal column range 0..LastCol.
   assign col     = {1'b0, lfsr_q};
   assign spawn_x = (col <= LastCol) ? col : col - (LastCol + 11'd1);

   assign y_next   = y_top_q + {7'd0, speed_q};
   assign pass_inc = pass_cnt_q + PCW'(1);

   // Next-state logic for the motion FSM, counters and speed level.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      pass_cnt_d  = pass_cnt_q;
      speed_d     = speed_q;
      x_left_d    = x_left_q;
      y_top_d     = y_top_q;
      passed_d    = 1'b0;

      if (!start_i) begin
         // Dropping start overrides everything, including a spawn or pass this cycle.
         state_d     = StIdle;
         frame_cnt_d = '0;
         pass_cnt_d  = '0;
         speed_d     = SpeedInit;
      end else begin
         case (state_q)
            StIdle: begin
               state_d     = StWait;
               frame_cnt_d = '0;
               pass_cnt_d  = '0;
               speed_d     = SpeedInit;
            end
            StWait: begin
               if (tick) begin
                  if (frame_cnt_q == FCW'(RESPAWN_FRAMES - 1)) begin
                     state_d     = StFall;
                     frame_cnt_d = '0;
                     x_left_d    = spawn_x;
                     y_top_d     = 11'd0;
                  end else begin
                     frame_cnt_d = frame_cnt_q + FCW'(1);
                  end
               end
            end
            StFall: begin
               if (hit_i) begin
                  // A hit takes priority over a same-cycle tick.
                  state_d = StWait;
               end else if (tick) begin
                  if (y_next >= MaxY) begin
                     state_d  = StWait;
                     passed_d = 1'b1;
                     if (pass_inc == PCW'(LEVEL_PASSES)) begin
                        pass_cnt_d = '0;
                        if (speed_q < SpeedMax) begin
                           speed_d = speed_q + 4'd1;
                        end
                     end else begin
                        pass_cnt_d = pass_inc;
                     end
                  end else begin
                     y_top_d = y_next;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Output values follow the next state so the bounds are registered, not decoded.
   always_comb begin
      active_d = (state_d == StFall);
      x1_d     = Park;
      x2_d     = Park;
      y1_d     = Park;
      y2_d     = Park;
      if (active_d) begin
         x1_d = x_left_d;
         x2_d = x_left_d + ObsWm1;
         y1_d = y_top_d;
         y2_d = y_top_d + ObsHm1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         dec_q       <= 1'b0;
         lfsr_q      <= LfsrSeed;
         frame_cnt_q <= '0;
         pass_cnt_q  <= '0;
         speed_q     <= SpeedInit;
         x_left_q    <= 11'd0;
         y_top_q     <= 11'd0;
         x1_q        <= Park;
         x2_q        <= Park;
         y1_q        <= Park;
         y2_q        <= Park;
         active_q    <= 1'b0;
         passed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         dec_q       <= dec;
         lfsr_q      <= lfsr_d;
         frame_cnt_q <= frame_cnt_d;
         pass_cnt_q  <= pass_cnt_d;
         speed_q     <= speed_d;
         x_left_q    <= x_left_d;
         y_top_q     <= y_top_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         y1_q        <= y1_d;
         y2_q        <= y2_d;
         active_q    <= active_d;
         passed_q    <= passed_d;
      end
   end

   assign x1_o         = x1_q;
   assign x2_o         = x2_q;
   assign y1_o         = y1_q;
   assign y2_o         = y2_q;
   assign obs_active_o = active_q;
   assign passed_o     = passed_q;
   assign speed_o      = speed_q;

endmodule

// File: tb/tb_obs_ctrl.sv
// Bench for obs_ctrl: a behavioural model pushes the expected outputs of every clock into a
// queue; a monitor pops and compares on the opposite edge. Directed phases add fixed checks.
module tb_obs_ctrl;

   localparam int RF   = 2;
   localparam int PARK = 2047;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] pix_x = 11'd0;
   logic [10:0] pix_y = 11'd0;
   logic        start = 1'b0;
   logic        hit   = 1'b0;
   logic [10:0] x1, x2, y1, y2;
   logic        obs_active, passed;
   logic [3:0]  speed;

   always #5 clk = ~clk;

   obs_ctrl #(
      .RESPAWN_FRAMES(RF)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .pix_x_i     (pix_x),
      .pix_y_i     (pix_y),
      .start_i     (start),
      .hit_i       (hit),
      .x1_o        (x1),
      .x2_o        (x2),
      .y1_o        (y1),
      .y2_o        (y2),
      .obs_active_o(obs_active),
      .passed_o    (passed),
      .speed_o     (speed)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int x1, x2, y1, y2, act, pas, spd;
   } exp_t;
   exp_t q[$];

   // Model state: mode 0 = stopped, 1 = waiting to spawn, 2 = falling.
   int m_mode = 0, m_x = 0, m_y = 0, m_speed = 1, m_passes = 0, m_frames = 0;
   int m_lfsr = 'h2A5, m_total = 0;
   bit m_dec_prev = 1'b0;

   // Behavioural reference model, evaluated at every rising edge.
   initial begin : model
      bit   dec, tick;
      int   c;
      exp_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_mode = 0; m_x = 0; m_y = 0; m_speed = 1; m_passes = 0; m_frames = 0;
            m_lfsr = 'h2A5; m_dec_prev = 1'b0;
            q.delete();
         end else begin
            dec        = (pix_y == 11'd481) && (pix_x == 11'd0);
            tick       = dec && !m_dec_prev;
            m_dec_prev = dec;
            c          = m_lfsr;
            m_lfsr     = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 'h3FF;
            e.pas      = 0;
            if (!start) begin
               m_mode = 0; m_speed = 1; m_passes = 0; m_frames = 0;
            end else if (m_mode == 0) begin
               m_mode = 1; m_frames = 0; m_passes = 0; m_speed = 1;
            end else if (m_mode == 1) begin
               if (tick) begin
                  m_frames++;
                  if (m_frames == RF) begin
                     m_frames = 0;
                     m_mode   = 2;
                     m_y      = 0;
                     m_x      = (c <= 608) ? c : c - 609;
                  end
               end
            end else begin
               if (hit) begin
                  m_mode = 1;
               end else if (tick) begin
                  if (m_y + m_speed >= 480) begin
                     e.pas = 1;
                     m_total++;
                     m_mode = 1;
                     m_passes++;
                     if (m_passes == 4) begin
                        m_passes = 0;
                        if (m_speed < 8) m_speed++;
                     end
                  end else begin
                     m_y += m_speed;
                  end
               end
            end
            e.act = (m_mode == 2) ? 1 : 0;
            e.x1  = e.act ? m_x : PARK;
            e.x2  = e.act ? m_x + 31 : PARK;
            e.y1  = e.act ? m_y : PARK;
            e.y2  = e.act ? m_y + 31 : PARK;
            e.spd = m_speed;
            q.push_back(e);
         end
      end
   end

   // Monitor: compares the registered outputs against the model on each falling edge.
   initial begin : monitor
      exp_t        e;
      logic [49:0] act_v, exp_v;
      forever begin
         @(negedge clk);
         if (rst_n && q.size() > 0) begin
            e     = q.pop_front();
            act_v = {x1, x2, y1, y2, obs_active, passed, speed};
            exp_v = {11'(e.x1), 11'(e.x2), 11'(e.y1), 11'(e.y2), 1'(e.act), 1'(e.pas),
                     4'(e.spd)};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL scoreboard @%0t: got x1=%0d x2=%0d y1=%0d y2=%0d act=%0b pas=%0b spd=%0d, expected x1=%0d x2=%0d y1=%0d y2=%0d act=%0d pas=%0d spd=%0d",
                        $time, x1, x2, y1, y2, obs_active, passed, speed,
                        e.x1, e.x2, e.y1, e.y2, e.act, e.pas, e.spd);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One frame: marker held for 'hold' clocks, then 'gap' clocks elsewhere on the screen.
   task automatic frame(input int hold, input int gap, input bit h);
      pix_x = 11'd0;
      pix_y = 11'd481;
      hit   = h;
      cyc(1);
      hit   = 1'b0;
      if (hold > 1) cyc(hold - 1);
      pix_x = 11'($urandom_range(1, 799));  // right row, wrong column: no tick
      cyc(1);
      pix_y = 11'($urandom_range(0, 480));
      if (gap > 1) cyc(gap - 1);
   endtask

   // Run fast frames until the model is falling at row y (any row when y < 0).
   task automatic wait_fall(input int y, input string name);
      int n = 0;
      while (!(m_mode == 2 && (y < 0 || m_y == y)) && n < 3000) begin
         frame(1, 1, 1'b0);
         n++;
      end
      if (n >= 3000) timeout(name);
   endtask

   task automatic run_passes(input int n, input string name);
      int target = m_total + n;
      int k      = 0;
      while (m_total < target && k < 30000) begin
         frame(1, 1, 1'b0);
         k++;
      end
      if (k >= 30000) timeout(name);
   endtask

   task automatic chk_parked(input string name);
      chk({name, "_x1"}, x1, PARK);
      chk({name, "_x2"}, x2, PARK);
      chk({name, "_y1"}, y1, PARK);
      chk({name, "_y2"}, y2, PARK);
      chk({name, "_act"}, obs_active, 0);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      // Reset values.
      cyc(3);
      chk_parked("reset");
      chk("reset_passed", passed, 0);
      chk("reset_speed", speed, 1);
      rst_n = 1'b1;

      // Frames running while stopped: nothing moves.
      for (int i = 0; i < 20; i++) frame($urandom_range(1, 4), $urandom_range(1, 3), 1'b0);
      chk_parked("idle");
      chk("idle_speed", speed, 1);

      // Start, then spawn on the second tick; a held marker ticks once.
      start = 1'b1;
      pix_y = 11'd0;
      cyc(2);
      frame(4, 2, 1'b0);
      chk("one_tick_act", obs_active, 0);
      pix_x = 11'd0;
      pix_y = 11'd481;
      cyc(1);
      chk("spawn_act", obs_active, 1);
      chk("spawn_y1", y1, 0);
      chk("spawn_y2", y2, 31);
      cyc(3);
      pix_y = 11'd100;
      cyc(2);
      chk("held_marker_y1", y1, 0);

      // Fall at speed 1 to the last visible row, then exit.
      repeat (479) frame(1, 1, 1'b0);
      chk("bottom_y1", y1, 479);
      chk("bottom_passed", passed, 0);
      pix_x = 11'd0;
      pix_y = 11'd481;
      cyc(1);
      chk("exit_passed", passed, 1);
      chk_parked("exit");
      pix_y = 11'd0;
      cyc(1);
      chk("exit_pulse_len", passed, 0);

      // Level-ups every four passes, saturating at 8.
      run_passes(2, "passes_3");
      chk("speed_after_3", speed, 1);
      run_passes(1, "passes_4");
      chk("speed_after_4", speed, 2);
      run_passes(23, "passes_27");
      chk("speed_after_27", speed, 7);
      run_passes(1, "passes_28");
      chk("speed_after_28", speed, 8);
      run_passes(12, "passes_40");
      chk("speed_after_40", speed, 8);

      // Drop start mid-fall.
      wait_fall(200, "fall_200");
      chk("pre_drop_y1", y1, 200);
      start = 1'b0;
      cyc(1);
      chk_parked("drop");
      chk("drop_speed", speed, 1);

      // Hit alone, then hit coincident with a tick.
      start = 1'b1;
      cyc(1);
      wait_fall(100, "fall_100");
      chk("pre_hit_y1", y1, 100);
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      chk_parked("hit");
      chk("hit_passed", passed, 0);
      chk("hit_speed", speed, 1);
      wait_fall(50, "fall_50");
      pix_x = 11'd0;
      pix_y = 11'd481;
      hit   = 1'b1;
      cyc(1);
      hit   = 1'b0;
      pix_y = 11'd0;
      chk_parked("hit_tick");
      chk("hit_tick_passed", passed, 0);
      cyc(1);

      // Randomised frames, hits and start drops against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) start = 1'b0;
         else start = 1'b1;
         frame($urandom_range(1, 4), $urandom_range(1, 3), ($urandom_range(0, 63) == 0));
      end

      // Asynchronous reset mid-fall.
      start = 1'b1;
      hit   = 1'b0;
      cyc(1);
      wait_fall(-1, "fall_any");
      #1 rst_n = 1'b0;
      #1;
      chk_parked("async_rst");
      chk("async_rst_passed", passed, 0);
      chk("async_rst_speed", speed, 1);
      @(negedge clk);
      rst_n = 1'b1;
      pix_y = 11'd0;
      cyc(2);
      frame(1, 1, 1'b0);
      frame(1, 1, 1'b0);
      chk("resume_act", obs_active, 1);
      chk("resume_y1", y1, 0);
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
